// File: rtl/gps_sample_fifo.sv
// GPS front-end sample capture, FIFO buffering and paced
// word presentation with sticky overflow and drop counting.
module gps_sample_fifo #(
  parameter int DEPTH_LOG2  = 3,
  parameter int HOLD_CYCLES = 5
) (
  input  logic       MCU_CLK_25_000,
  input  logic       RESET_N,
  input  logic       GPS_CLK,
  input  logic       GPS_I0,
  input  logic       GPS_I1,
  input  logic       GPS_Q0,
  input  logic       GPS_Q1,
  output logic       OUT_I0,
  output logic       OUT_I1,
  output logic       OUT_Q0,
  output logic       OUT_Q1,
  output logic       DATAREADY,
  output logic       OVERFLOW,
  output logic [7:0] OVF_COUNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] FULL_CNT =
    CW'(DEPTH);
  localparam logic [7:0] HOLD_LAST =
    8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PRESENT,
    S_HOLD
  } state_e;

  // Input synchronisers
  logic [2:0]    clk_sync_q;
  logic [3:0]    dat_s1_q;
  logic [3:0]    dat_s2_q;
  logic          gps_rise;

  // FIFO state
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] wptr_d;
  logic [AW-1:0] rptr_q;
  logic [AW-1:0] rptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;
  logic          ovf_d;
  logic [7:0]    ovf_cnt_q;
  logic [7:0]    ovf_cnt_d;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          drop;

  // Read FSM state
  state_e        state_q;
  logic [7:0]    hold_q;
  logic [3:0]    out_q;
  logic          rdy_q;

  // Clock and data take the same two-flop path so the
  // data seen at sync2 belongs to the detected edge.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (!RESET_N) begin
      clk_sync_q <= '0;
      dat_s1_q   <= '0;
      dat_s2_q   <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], GPS_CLK};
      dat_s1_q   <= {GPS_I0, GPS_I1,
                     GPS_Q0, GPS_Q1};
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign gps_rise = clk_sync_q[1] & ~clk_sync_q[2];

  assign push  = gps_rise;
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign pop   = (state_q == S_LOAD) & ~empty;

  // A pop in the same cycle frees the slot, so a push
  // at full is only dropped when nothing is popped.
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // FIFO pointer, occupancy and loss bookkeeping
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    ovf_cnt_d = ovf_cnt_q;

    if (do_push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end

    unique case ({do_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_cnt_q != 8'hFF) begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
    end
  end

  // FIFO control registers
  always_ff @(posedge MCU_CLK_25_000) begin
    if (!RESET_N) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Sample storage; contents are don't-care while empty
  always_ff @(posedge MCU_CLK_25_000) begin
    if (do_push) begin
      mem_q[wptr_q] <= dat_s2_q;
    end
  end

  // Read FSM: load, one-cycle ready pulse, then hold the
  // word long enough for the bridge to shift it out.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          out_q   <= mem_q[rptr_q];
          hold_q  <= '0;
          rdy_q   <= 1'b1;
          state_q <= S_PRESENT;
        end
        S_PRESENT: begin
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= empty ? S_IDLE : S_LOAD;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign OUT_I0    = out_q[3];
  assign OUT_I1    = out_q[2];
  assign OUT_Q0    = out_q[1];
  assign OUT_Q1    = out_q[0];
  assign DATAREADY = rdy_q;
  assign OVERFLOW  = ovf_q;
  assign OVF_COUNT = ovf_cnt_q;

endmodule

// File: tb/tb_gps_sample_fifo.sv
// Directed bench for gps_sample_fifo: latency, pacing,
// overflow, saturation and mid-word reset.
module tb_gps_sample_fifo;

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic       GPS_CLK = 1'b0;
  logic       GPS_I0 = 1'b0;
  logic       GPS_I1 = 1'b0;
  logic       GPS_Q0 = 1'b0;
  logic       GPS_Q1 = 1'b0;
  logic       OUT_I0;
  logic       OUT_I1;
  logic       OUT_Q0;
  logic       OUT_Q1;
  logic       DATAREADY;
  logic       OVERFLOW;
  logic [7:0] OVF_COUNT;

  logic [3:0] out_w;
  assign out_w = {OUT_I0, OUT_I1, OUT_Q0, OUT_Q1};

  gps_sample_fifo #(
    .DEPTH_LOG2 (3),
    .HOLD_CYCLES(5)
  ) dut (
    .MCU_CLK_25_000(clk),
    .RESET_N       (RESET_N),
    .GPS_CLK       (GPS_CLK),
    .GPS_I0        (GPS_I0),
    .GPS_I1        (GPS_I1),
    .GPS_Q0        (GPS_Q0),
    .GPS_Q1        (GPS_Q1),
    .OUT_I0        (OUT_I0),
    .OUT_I1        (OUT_I1),
    .OUT_Q0        (OUT_Q0),
    .OUT_Q1        (OUT_Q1),
    .DATAREADY     (DATAREADY),
    .OVERFLOW      (OVERFLOW),
    .OVF_COUNT     (OVF_COUNT)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         pulse_cyc[$];
  logic [3:0] pulse_word[$];
  logic [3:0] prev_w = 4'h0;
  logic       prev_rdy = 1'b0;

  typedef struct {
    logic [3:0] word;
    logic [3:0] exp_out;
    int         exp_lat;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Pulse log plus output-stability watch
  always @(posedge clk) begin
    #1;
    cyc++;
    if (RESET_N === 1'b1) begin
      if (DATAREADY === 1'b1) begin
        pulse_cyc.push_back(cyc);
        pulse_word.push_back(out_w);
        checks++;
        if (prev_rdy === 1'b1) begin
          errors++;
          $display("FAIL rdy_width: got 2 cycles expected 1");
        end
      end
      if (out_w !== prev_w) begin
        checks++;
        if (DATAREADY !== 1'b1) begin
          errors++;
          $display("FAIL out_stable: got %0h->%0h without DATAREADY expected no change",
                   prev_w, out_w);
        end
      end
    end
    prev_w   = out_w;
    prev_rdy = DATAREADY;
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    RESET_N = 1'b0;
    GPS_CLK = 1'b0;
    {GPS_I0, GPS_I1, GPS_Q0, GPS_Q1} = 4'h0;
    repeat (n) @(negedge clk);
    RESET_N = 1'b1;
  endtask

  task automatic clear_log();
    pulse_cyc.delete();
    pulse_word.delete();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out"}, 32'(out_w), 32'h0);
    chk({tag, "_rdy"}, 32'(DATAREADY), 32'h0);
    chk({tag, "_ovf"}, 32'(OVERFLOW), 32'h0);
    chk({tag, "_cnt"}, 32'(OVF_COUNT), 32'h0);
  endtask

  // One GPS sample: 2 cycles low with new data, 2 high
  task automatic gps_pulse(input logic [3:0] w,
                           output int c0);
    {GPS_I0, GPS_I1, GPS_Q0, GPS_Q1} = w;
    GPS_CLK = 1'b0;
    repeat (2) @(negedge clk);
    GPS_CLK = 1'b1;
    c0 = cyc;
    repeat (2) @(negedge clk);
    GPS_CLK = 1'b0;
  endtask

  task automatic chk_spacing(input string tag);
    for (int i = 1; i < pulse_cyc.size(); i++) begin
      chk({tag, "_gap"},
          32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd7);
    end
  endtask

  initial begin
    int c0;
    int cfirst;
    int nsaved;
    logic [3:0] w;

    vt[0] = '{4'b1011, 4'b1011, 5};
    vt[1] = '{4'b0000, 4'b0000, 5};
    vt[2] = '{4'b1111, 4'b1111, 5};
    vt[3] = '{4'b0101, 4'b0101, 5};
    vt[4] = '{4'b1000, 4'b1000, 5};
    vt[5] = '{4'b0001, 4'b0001, 5};

    // Single-edge vectors from reset
    for (int v = 0; v < 6; v++) begin
      do_reset(3);
      chk_reset_state("rst");
      clear_log();
      gps_pulse(vt[v].word, c0);
      repeat (16) @(negedge clk);
      chk("one_pulse", 32'(pulse_cyc.size()), 32'd1);
      if (pulse_cyc.size() > 0) begin
        chk("latency", 32'(pulse_cyc[0] - c0),
            32'(vt[v].exp_lat));
        chk("word", 32'(pulse_word[0]),
            32'(vt[v].exp_out));
      end
      chk("word_held", 32'(out_w), 32'(vt[v].exp_out));
      chk("no_ovf", 32'(OVERFLOW), 32'h0);
    end

    // Burst of 8 distinct words, 4-cycle period
    do_reset(3);
    clear_log();
    cfirst = 0;
    for (int i = 0; i < 8; i++) begin
      w = 4'(i);
      gps_pulse(w, c0);
      if (i == 0) cfirst = c0;
    end
    repeat (60) @(negedge clk);
    chk("burst_n", 32'(pulse_cyc.size()), 32'd8);
    if (pulse_cyc.size() > 0) begin
      chk("burst_lat", 32'(pulse_cyc[0] - cfirst), 32'd5);
    end
    for (int i = 0; i < pulse_word.size(); i++) begin
      chk("burst_word", 32'(pulse_word[i]), 32'(i));
    end
    chk_spacing("burst");
    chk("burst_ovf", 32'(OVERFLOW), 32'h0);
    chk("burst_cnt", 32'(OVF_COUNT), 32'h0);

    // 20 edges: FIFO fills, a push lands on a LOAD at
    // full (kept), the last edge is the only drop.
    do_reset(3);
    clear_log();
    for (int i = 0; i < 20; i++) begin
      w = 4'(i);
      gps_pulse(w, c0);
    end
    repeat (160) @(negedge clk);
    chk("ovf_flag", 32'(OVERFLOW), 32'h1);
    chk("ovf_cnt", 32'(OVF_COUNT), 32'd1);
    chk("ovf_delivered", 32'(pulse_cyc.size()), 32'd19);
    for (int i = 0; i < pulse_word.size(); i++) begin
      chk("full_pushpop_word",
          32'(pulse_word[i]), 32'(i % 16));
    end
    chk_spacing("ovf");

    // Sustained overrun: counter must stop at 255
    do_reset(3);
    clear_log();
    for (int i = 0; i < 900; i++) begin
      w = 4'(i);
      gps_pulse(w, c0);
    end
    repeat (4) @(negedge clk);
    chk("sat_cnt", 32'(OVF_COUNT), 32'hFF);
    chk("sat_flag", 32'(OVERFLOW), 32'h1);
    for (int i = 0; i < 20; i++) begin
      w = 4'(i);
      gps_pulse(w, c0);
    end
    repeat (4) @(negedge clk);
    chk("sat_hold", 32'(OVF_COUNT), 32'hFF);
    chk_spacing("sat");

    // Reset during HOLD with 5 entries queued
    do_reset(3);
    clear_log();
    for (int i = 0; i < 12; i++) begin
      w = 4'(i + 1);
      gps_pulse(w, c0);
    end
    repeat (3) @(negedge clk);
    chk("pre_rst_pulses", 32'(pulse_cyc.size()), 32'd7);
    chk("pre_rst_rdy", 32'(DATAREADY), 32'h0);
    chk("pre_rst_out_nz", 32'(out_w != 4'h0), 32'h1);
    RESET_N = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");
    @(negedge clk);
    RESET_N = 1'b1;
    nsaved = pulse_cyc.size();
    repeat (40) @(negedge clk);
    chk("post_rst_pulses",
        32'(pulse_cyc.size() - nsaved), 32'd0);
    chk_reset_state("post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
